// File: rtl/date_sequencer.sv
// date_sequencer
//
// Owns the calendar date (day/month/year, epoch 2000-2099). It advances the
// date by one day per day_tick pulse and lets the display/UI layer program a
// new date through a validated set handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   day_tick   one-cycle pulse: advance the date by one day
//   set_req    level request to load set_day/set_month/set_year
//   set_day    requested day (binary)
//   set_month  requested month (binary)
//   set_year   requested year 0..99 (binary)
//   day        current day 1..31
//   month      current month 1..12
//   year       current year 0..99
//   leap       1 when year[1:0] == 0
//   new_month  one-cycle pulse on a month rollover
//   year_wrap  one-cycle pulse on the 99 -> 0 rollover
//   set_ack    one-cycle pulse: load accepted
//   set_err    one-cycle pulse: load rejected, date unchanged
//   busy       1 while the set FSM is not in IDLE
//   dbg_state  current set FSM state (0 IDLE, 1 CHECK, 2 WAIT_REL)
//
// Set handshake: the requester raises set_req with stable set_* values and
// holds it until it sees set_ack or set_err. The set_* values are captured on
// the edge that leaves IDLE, so they only need to be stable up to that edge.
// Exactly one ack/err pulse is produced per request; the FSM then waits for
// set_req to drop before it will accept another request.
//
// All outputs are registered.

module date_sequencer #(
  parameter int YEAR_RST  = 0,
  parameter int MONTH_RST = 1,
  parameter int DAY_RST   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       set_req,
  input  logic [4:0] set_day,
  input  logic [3:0] set_month,
  input  logic [6:0] set_year,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       leap,
  output logic       new_month,
  output logic       year_wrap,
  output logic       set_ack,
  output logic       set_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  // A tick that lands while CHECK is busy is remembered here (depth one).
  logic       pending;
  logic       pending_next;

  // Shadow copy of the requested date, captured when leaving IDLE.
  logic [4:0] shd_day;
  logic [3:0] shd_month;
  logic [6:0] shd_year;
  logic       shd_ok;

  logic [4:0] day_next;
  logic [3:0] month_next;
  logic [6:0] year_next;
  logic       new_month_next;
  logic       year_wrap_next;
  logic       ack_next;
  logic       err_next;
  logic       adv;
  logic       load;
  logic [4:0] cur_dim;

  // Days in month. Only years 0..99 are legal, so year mod 4 is the whole
  // leap rule (2000 is a leap year).
  function automatic logic [4:0] dim(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd2:                         d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:      d = 5'd30;
      default:                      d = 5'd31;
    endcase
    return d;
  endfunction

  assign shd_ok = (shd_month >= 4'd1) && (shd_month <= 4'd12) &&
                  (shd_year <= 7'd99) &&
                  (shd_day >= 5'd1) && (shd_day <= dim(shd_month, shd_year));

  assign cur_dim   = dim(month, year);
  assign dbg_state = state;

  // Next-state, handshake and date-update logic.
  always_comb begin
    state_next     = state;
    pending_next   = pending;
    adv            = 1'b0;
    load           = 1'b0;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    day_next       = day;
    month_next     = month;
    year_next      = year;
    new_month_next = 1'b0;
    year_wrap_next = 1'b0;

    case (state)
      IDLE: begin
        // A tick coinciding with a request still advances the date; any
        // accepted load in CHECK simply overwrites the result.
        adv          = day_tick | pending;
        pending_next = pending & day_tick;
        if (set_req) state_next = CHECK;
      end
      CHECK: begin
        state_next = WAIT_REL;
        if (shd_ok) begin
          // Loaded date wins over any tick seen on this edge.
          load         = 1'b1;
          ack_next     = 1'b1;
          pending_next = 1'b0;
        end else begin
          err_next = 1'b1;
          if (day_tick) pending_next = 1'b1;
        end
      end
      WAIT_REL: begin
        adv          = day_tick | pending;
        pending_next = pending & day_tick;
        if (!set_req) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pending_next = 1'b0;
      end
    endcase

    if (load) begin
      day_next   = shd_day;
      month_next = shd_month;
      year_next  = shd_year;
    end else if (adv) begin
      // >= rather than == keeps the counter self-correcting if it ever holds
      // an out-of-range day.
      if (day >= cur_dim) begin
        day_next       = 5'd1;
        new_month_next = 1'b1;
        if (month >= 4'd12) begin
          month_next = 4'd1;
          if (year >= 7'd99) begin
            year_next      = 7'd0;
            year_wrap_next = 1'b1;
          end else begin
            year_next = year + 7'd1;
          end
        end else begin
          month_next = month + 4'd1;
        end
      end else begin
        day_next = day + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      shd_day   <= 5'd0;
      shd_month <= 4'd0;
      shd_year  <= 7'd0;
      day       <= 5'(DAY_RST);
      month     <= 4'(MONTH_RST);
      year      <= 7'(YEAR_RST);
      leap      <= ((YEAR_RST % 4) == 0);
      new_month <= 1'b0;
      year_wrap <= 1'b0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      if ((state == IDLE) && set_req) begin
        shd_day   <= set_day;
        shd_month <= set_month;
        shd_year  <= set_year;
      end
      day       <= day_next;
      month     <= month_next;
      year      <= year_next;
      leap      <= (year_next[1:0] == 2'b00);
      new_month <= new_month_next;
      year_wrap <= year_wrap_next;
      set_ack   <= ack_next;
      set_err   <= err_next;
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_date_sequencer.sv
// Testbench for date_sequencer: table of set/tick vectors plus hand-written
// sequences for CHECK-cycle ticks, same-edge events and mid-operation reset.
// Set responses go through an expected queue popped when ack/err appears.

module tb_date_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       day_tick;
  logic       set_req;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic       leap;
  logic       new_month;
  logic       year_wrap;
  logic       set_ack;
  logic       set_err;
  logic       busy;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  date_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .day_tick  (day_tick),
    .set_req   (set_req),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .day       (day),
    .month     (month),
    .year      (year),
    .leap      (leap),
    .new_month (new_month),
    .year_wrap (year_wrap),
    .set_ack   (set_ack),
    .set_err   (set_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: {ack, err, day[4:0], month[3:0], year[6:0]}
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (set_ack || set_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got ack=%0b err=%0b expected none at %0t",
                 set_ack, set_err, $time);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("set_response", {14'd0, set_ack, set_err, day, month, year}, {14'd0, e});
        check("busy_at_response", busy, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one set request and waits (bounded) for its ack/err pulse.
  // Returns at the negedge where the pulse is visible.
  task automatic do_set(input logic [4:0] sd, input logic [3:0] sm, input logic [6:0] sy,
                        input logic ok, input logic [4:0] ed, input logic [3:0] em,
                        input logic [6:0] ey, input logic rel);
    bit got;
    @(negedge clk);
    set_day   = sd;
    set_month = sm;
    set_year  = sy;
    set_req   = 1'b1;
    if (ok) exp_q.push_back({1'b1, 1'b0, sd, sm, sy});
    else    exp_q.push_back({1'b0, 1'b1, ed, em, ey});
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (set_ack || set_err) got = 1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL set_timeout: got no ack/err expected a pulse within 8 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (rel) set_req = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last ticked edge.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      day_tick = 1'b1;
      @(negedge clk);
      day_tick = 1'b0;
    end
  endtask

  task automatic check_date(input string name, input logic [4:0] d, input logic [3:0] m,
                            input logic [6:0] y);
    check(name, {16'd0, day, month, year}, {16'd0, d, m, y});
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [4:0] sd;
    logic [3:0] sm;
    logic [6:0] sy;
    logic [3:0] ticks;
    logic       ok;
    logic [4:0] ed;
    logic [3:0] em;
    logic [6:0] ey;
    logic       enm;
    logic       eyw;
    logic       eleap;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(input int sd, input int sm, input int sy, input int t,
                              input bit ok, input int ed, input int em, input int ey,
                              input bit enm, input bit eyw, input bit el);
    vec_t v;
    v.sd = 5'(sd); v.sm = 4'(sm); v.sy = 7'(sy); v.ticks = 4'(t); v.ok = ok;
    v.ed = 5'(ed); v.em = 4'(em); v.ey = 7'(ey);
    v.enm = enm; v.eyw = eyw; v.eleap = el;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected end of test before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // set day/mon/year, ticks, ok, expected day/mon/year, new_month, year_wrap, leap
    vecs[0]  = mk(28,  2,   1, 1, 1,  1,  3,  1, 1, 0, 0);
    vecs[1]  = mk(28,  2,   4, 1, 1, 29,  2,  4, 0, 0, 1);
    vecs[2]  = mk(28,  2,   4, 2, 1,  1,  3,  4, 1, 0, 1);
    vecs[3]  = mk(30,  4,  10, 1, 1,  1,  5, 10, 1, 0, 0);
    vecs[4]  = mk(31, 12,  99, 1, 1,  1,  1,  0, 1, 1, 1);
    vecs[5]  = mk(15,  6,  20, 3, 1, 18,  6, 20, 0, 0, 1);
    vecs[6]  = mk(29,  2,   3, 0, 0, 18,  6, 20, 0, 0, 1);
    vecs[7]  = mk( 1, 13,   5, 0, 0, 18,  6, 20, 0, 0, 1);
    vecs[8]  = mk( 0,  1,   5, 0, 0, 18,  6, 20, 0, 0, 1);
    vecs[9]  = mk( 1,  1, 100, 0, 0, 18,  6, 20, 0, 0, 1);
    vecs[10] = mk(31,  4,   5, 0, 0, 18,  6, 20, 0, 0, 1);
    vecs[11] = mk(31,  1,  50, 1, 1,  1,  2, 50, 1, 0, 0);
    vecs[12] = mk(31, 12,  98, 1, 1,  1,  1, 99, 1, 0, 0);
    vecs[13] = mk(29,  2,  96, 1, 1,  1,  3, 96, 1, 0, 1);
    vecs[14] = mk( 5,  0,   5, 0, 0,  1,  3, 96, 0, 0, 1);

    rst = 1'b0; day_tick = 1'b0; set_req = 1'b0;
    set_day = 5'd0; set_month = 4'd0; set_year = 7'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check_date("reset_date", 5'd1, 4'd1, 7'd0);
    check("reset_leap", leap, 1);
    check("reset_busy", busy, 0);
    check("reset_pulses", {new_month, year_wrap, set_ack, set_err}, 0);
    check("reset_state", dbg_state, 0);

    // Table-driven set/tick vectors
    for (int i = 0; i < NV; i++) begin
      do_set(vecs[i].sd, vecs[i].sm, vecs[i].sy, vecs[i].ok,
             vecs[i].ed, vecs[i].em, vecs[i].ey, 1'b1);
      if (vecs[i].ok) tick_n(int'(vecs[i].ticks));
      check_date($sformatf("vec%0d_date", i), vecs[i].ed, vecs[i].em, vecs[i].ey);
      check($sformatf("vec%0d_leap", i), leap, vecs[i].eleap);
      check($sformatf("vec%0d_pulses", i), {new_month, year_wrap}, {vecs[i].enm, vecs[i].eyw});
      @(negedge clk);
      check($sformatf("vec%0d_pulses_clear", i), {new_month, year_wrap}, 0);
    end

    // Hold set_req for 5 cycles: one ack, busy throughout, idle after release
    begin
      int pulses;
      int busy_low;
      @(negedge clk);
      set_day = 5'd10; set_month = 4'd10; set_year = 7'd10; set_req = 1'b1;
      exp_q.push_back({1'b1, 1'b0, 5'd10, 4'd10, 7'd10});
      pulses = 0; busy_low = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (set_ack || set_err) pulses++;
        if (!busy) busy_low++;
      end
      check("hold_single_pulse", pulses, 1);
      check("hold_busy_cycles_low", busy_low, 0);
      check("hold_state_wait_rel", dbg_state, 2);
      set_req = 1'b0;
      @(negedge clk);
      check("hold_release_busy", busy, 0);
      check("hold_release_state", dbg_state, 0);
    end

    // Invalid set with ticks in CHECK and WAIT_REL: WAIT_REL tick advances
    // immediately, the CHECK tick is applied on the first tick-free cycle.
    @(negedge clk);
    set_day = 5'd0; set_month = 4'd10; set_year = 7'd10; set_req = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 5'd10, 4'd10, 7'd10});
    @(negedge clk);
    check("pend_in_check", dbg_state, 1);
    day_tick = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    check_date("pend_after_check", 5'd10, 4'd10, 7'd10);
    @(negedge clk);
    day_tick = 1'b0;
    check_date("pend_tick_in_wait", 5'd11, 4'd10, 7'd10);
    @(negedge clk);
    check_date("pend_applied", 5'd12, 4'd10, 7'd10);
    @(negedge clk);
    check_date("pend_cleared", 5'd12, 4'd10, 7'd10);

    // Valid set with a tick in CHECK: the load wins, the tick is discarded
    @(negedge clk);
    set_day = 5'd5; set_month = 4'd5; set_year = 7'd5; set_req = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 5'd5, 4'd5, 7'd5});
    @(negedge clk);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
    set_req = 1'b0;
    @(negedge clk);
    check_date("load_wins_no_pending", 5'd5, 4'd5, 7'd5);
    @(negedge clk);
    check_date("load_wins_stable", 5'd5, 4'd5, 7'd5);

    // Tick and set_req on the same edge in IDLE: tick first, then the load
    set_day = 5'd20; set_month = 4'd7; set_year = 7'd7; set_req = 1'b1; day_tick = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 5'd20, 4'd7, 7'd7});
    @(negedge clk);
    day_tick = 1'b0;
    check_date("same_edge_tick", 5'd6, 4'd5, 7'd5);
    @(negedge clk);
    set_req = 1'b0;
    @(negedge clk);
    check_date("same_edge_load", 5'd20, 4'd7, 7'd7);
    check("same_edge_idle", dbg_state, 0);

    // Reset while in WAIT_REL
    do_set(5'd1, 4'd8, 7'd8, 1'b1, 5'd1, 4'd8, 7'd8, 1'b0);
    @(negedge clk);
    check("rst_pre_state", dbg_state, 2);
    #2 rst = 1'b0;
    #1;
    set_req = 1'b0;
    check_date("rst_mid_date", 5'd1, 4'd1, 7'd0);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_busy_leap", {busy, leap}, 2'b01);
    check("rst_mid_pulses", {new_month, year_wrap, set_ack, set_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (set_ack || set_err || new_month || year_wrap || busy) seen++;
      end
      check("rst_after_quiet", seen, 0);
    end
    check_date("rst_after_date", 5'd1, 4'd1, 7'd0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
